// File: rtl/axis_stream_pkg.sv
// Shared types and helpers for the AXI-Stream sample pacer and its FIFO.
//   DEFAULT_DATA_WIDTH : default sample width in bits
//   sample_t           : signed sample at the default width
//   slot_state_t       : output slot state (idle / holding a sample)
//   clog2_depth()      : ceil(log2(n)) usable in constant expressions
package axis_stream_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 16;

   typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

   typedef enum logic {
      SLOT_IDLE = 1'b0,
      SLOT_FULL = 1'b1
   } slot_state_t;

   // Smallest w such that 2**w >= n.
   function automatic int unsigned clog2_depth(input int unsigned n);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write strobe, accepted only when not full
//   wr_data    : data to enqueue
//   rd_en      : pop strobe, honoured only when not empty
//   rd_data    : current head of the queue
//   full       : registered, level == DEPTH
//   empty      : registered, level == 0
//   level      : registered occupancy 0..DEPTH
module sync_fifo
   import axis_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic                       rd_en,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = clog2_depth(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr_q;
   logic [AW-1:0]         rd_ptr_q;
   logic [LW-1:0]         level_q;
   logic [LW-1:0]         level_nxt;
   logic                  full_q;
   logic                  nonempty_q;
   logic                  wr_acc_c;
   logic                  rd_acc_c;

   assign wr_acc_c = wr_en & ~full_q;
   assign rd_acc_c = rd_en & nonempty_q;

   // Occupancy update; a simultaneous write and pop cancel out.
   always_comb begin
      level_nxt = level_q;
      unique case ({wr_acc_c, rd_acc_c})
         2'b10:   level_nxt = level_q + LW'(1);
         2'b01:   level_nxt = level_q - LW'(1);
         default: level_nxt = level_q;
      endcase
   end

   // Pointers, occupancy and registered flags; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         nonempty_q <= 1'b0;
      end else begin
         if (wr_acc_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_acc_c) rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q    <= level_nxt;
         full_q     <= (level_nxt == LW'(DEPTH));
         nonempty_q <= (level_nxt != '0);
      end
   end

   // Storage array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (wr_acc_c) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr_q];
   assign full    = full_q;
   assign empty   = ~nonempty_q;
   assign level   = level_q;

endmodule

// File: rtl/axis_sample_pacer.sv
// AXI-Stream source that releases one queued sample per rate tick and holds
// it until the downstream accepts it, with saturating event counters.
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : rate-tick generator enable
//   wr_en, wr_data  : sample write port into the internal FIFO
//   full, level     : FIFO full flag and occupancy
//   m_axis_*        : AXI-Stream master (tdata, tvalid, tready)
//   underrun_count  : ticks that found the FIFO empty
//   stall_count     : ticks that found the previous sample still unaccepted
//   overflow_count  : writes dropped because the FIFO was full
module axis_sample_pacer
   import axis_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned RATE_DIV   = 5,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [CNT_WIDTH-1:0]   underrun_count,
   output logic [CNT_WIDTH-1:0]   stall_count,
   output logic [CNT_WIDTH-1:0]   overflow_count
);

   localparam int unsigned LW    = clog2_depth(DEPTH) + 1;
   localparam int unsigned DIV_W = (RATE_DIV > 1) ? clog2_depth(RATE_DIV) : 1;

   logic [DIV_W-1:0]      div_cnt_q;
   logic                  tick_c;

   slot_state_t           slot_q;
   slot_state_t           slot_nxt;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic [DATA_WIDTH-1:0] tdata_nxt;
   logic                  pop_c;
   logic                  underrun_inc_c;
   logic                  stall_inc_c;
   logic                  overflow_inc_c;

   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [LW-1:0]         fifo_level;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop_c),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Rate divider: tick on the last count of each period, held at 0 when disabled.
   assign tick_c = enable && (div_cnt_q == DIV_W'(RATE_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                div_cnt_q <= '0;
      else if (!enable || tick_c) div_cnt_q <= '0;
      else                       div_cnt_q <= div_cnt_q + DIV_W'(1);
   end

   // Output slot state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q  <= SLOT_IDLE;
         tdata_q <= '0;
      end else begin
         slot_q  <= slot_nxt;
         tdata_q <= tdata_nxt;
      end
   end

   // Slot next-state: a tick looks at the slot as it stands after this
   // cycle's handshake, so accept-and-tick refills in the same cycle.
   always_comb begin
      slot_nxt       = slot_q;
      tdata_nxt      = tdata_q;
      pop_c          = 1'b0;
      underrun_inc_c = 1'b0;
      stall_inc_c    = 1'b0;
      if (tick_c) begin
         if ((slot_q == SLOT_FULL) && !m_axis_tready) begin
            stall_inc_c = 1'b1;
         end else if (!fifo_empty) begin
            pop_c     = 1'b1;
            slot_nxt  = SLOT_FULL;
            tdata_nxt = fifo_rd_data;
         end else begin
            underrun_inc_c = 1'b1;
            slot_nxt       = SLOT_IDLE;
         end
      end else if ((slot_q == SLOT_FULL) && m_axis_tready) begin
         slot_nxt = SLOT_IDLE;
      end
   end

   // Dropped writes are judged against the registered full flag.
   assign overflow_inc_c = wr_en & fifo_full;

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_count <= '0;
         stall_count    <= '0;
         overflow_count <= '0;
      end else begin
         if (underrun_inc_c && (underrun_count != '1))
            underrun_count <= underrun_count + CNT_WIDTH'(1);
         if (stall_inc_c && (stall_count != '1))
            stall_count <= stall_count + CNT_WIDTH'(1);
         if (overflow_inc_c && (overflow_count != '1))
            overflow_count <= overflow_count + CNT_WIDTH'(1);
      end
   end

   assign m_axis_tvalid = (slot_q == SLOT_FULL);
   assign m_axis_tdata  = tdata_q;
   assign full          = fifo_full;
   assign level         = fifo_level;

endmodule

// File: tb/tb_axis_sample_pacer.sv
// Self-checking bench: one pacer at RATE_DIV=5 and one at RATE_DIV=1,
// table-driven overflow vectors, scoreboard queues for emitted samples.
module tb_axis_sample_pacer;

   logic clk;
   logic rst_n;

   logic        enable5, wr_en5, full5, tvalid5, tready5;
   logic [15:0] wr_data5, tdata5, und5, stall5, ovf5;
   logic [4:0]  level5;

   logic        enable1, wr_en1, full1, tvalid1, tready1;
   logic [15:0] wr_data1, tdata1, und1, stall1, ovf1;
   logic [4:0]  level1;

   logic [15:0] q5[$];
   logic [15:0] q1[$];

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic        wr_en;
      logic [15:0] data;
      logic        push;
      logic        exp_full;
      logic [4:0]  exp_level;
      logic [15:0] exp_ovf;
   } vec_t;

   vec_t vecs[18];

   axis_sample_pacer u_dut5 (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable5),
      .wr_en          (wr_en5),
      .wr_data        (wr_data5),
      .full           (full5),
      .level          (level5),
      .m_axis_tdata   (tdata5),
      .m_axis_tvalid  (tvalid5),
      .m_axis_tready  (tready5),
      .underrun_count (und5),
      .stall_count    (stall5),
      .overflow_count (ovf5)
   );

   axis_sample_pacer #(.RATE_DIV(1)) u_dut1 (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable1),
      .wr_en          (wr_en1),
      .wr_data        (wr_data1),
      .full           (full1),
      .level          (level1),
      .m_axis_tdata   (tdata1),
      .m_axis_tvalid  (tvalid1),
      .m_axis_tready  (tready1),
      .underrun_count (und1),
      .stall_count    (stall1),
      .overflow_count (ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic fail_msg(input string nm);
      n_chk++;
      $display("FAIL %s", nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      enable5 = 1'b0; wr_en5 = 1'b0; wr_data5 = '0; tready5 = 1'b0;
      enable1 = 1'b0; wr_en1 = 1'b0; wr_data1 = '0; tready1 = 1'b0;
      q5.delete();
      q1.delete();
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic wr5(input logic [15:0] d);
      wr_en5 = 1'b1; wr_data5 = d; q5.push_back(d);
      step();
      wr_en5 = 1'b0;
   endtask

   task automatic wr1(input logic [15:0] d);
      wr_en1 = 1'b1; wr_data1 = d; q1.push_back(d);
      step();
      wr_en1 = 1'b0;
   endtask

   // Scoreboards: a handshake seen mid-cycle completes at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && tvalid5 && tready5) begin
         if (q5.size() == 0) fail_msg($sformatf("sb5_extra_output tdata=0x%0h", tdata5));
         else chk("sb5_tdata", 32'(tdata5), 32'(q5.pop_front()));
      end
      if (rst_n && tvalid1 && tready1) begin
         if (q1.size() == 0) fail_msg($sformatf("sb1_extra_output tdata=0x%0h", tdata1));
         else chk("sb1_tdata", 32'(tdata1), 32'(q1.pop_front()));
      end
   end

   initial begin
      int lvl;
      int ovf;
      int t;

      // Overflow vectors: 17 writes with the tick generator off, then one idle cycle.
      lvl = 0;
      ovf = 0;
      for (int i = 0; i < 18; i++) begin
         vecs[i].wr_en = (i < 17);
         vecs[i].data  = 16'h0100 + 16'(i);
         vecs[i].push  = vecs[i].wr_en && (lvl < 16);
         if (vecs[i].push) lvl++;
         else if (vecs[i].wr_en) ovf++;
         vecs[i].exp_full  = (lvl == 16);
         vecs[i].exp_level = 5'(lvl);
         vecs[i].exp_ovf   = 16'(ovf);
      end

      // Reset values, checked while reset is asserted.
      rst_n = 1'b0;
      enable5 = 1'b0; wr_en5 = 1'b0; wr_data5 = '0; tready5 = 1'b0;
      enable1 = 1'b0; wr_en1 = 1'b0; wr_data1 = '0; tready1 = 1'b0;
      step();
      chk("rst_tvalid5", 32'(tvalid5), 0);
      chk("rst_tdata5",  32'(tdata5),  0);
      chk("rst_level5",  32'(level5),  0);
      chk("rst_full5",   32'(full5),   0);
      chk("rst_und5",    32'(und5),    0);
      chk("rst_stall5",  32'(stall5),  0);
      chk("rst_ovf5",    32'(ovf5),    0);
      chk("rst_tvalid1", 32'(tvalid1), 0);
      chk("rst_level1",  32'(level1),  0);
      chk("rst_full1",   32'(full1),   0);
      chk("rst_cnt1",    32'(und1 | stall1 | ovf1 | tdata1), 0);

      // Basic pacing: one-cycle tvalid every 5 cycles, then underruns.
      do_reset();
      tready5 = 1'b1;
      wr5(16'h7FFF);
      wr5(16'h0001);
      wr5(16'h8000);
      enable5 = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         step();
         chk($sformatf("pace_tvalid_c%0d", i), 32'(tvalid5),
             32'((i == 5) || (i == 10) || (i == 15)));
         if (i == 19) chk("pace_und_before", 32'(und5), 0);
         if (i == 20) chk("pace_und_first",  32'(und5), 1);
         if (i == 25) chk("pace_und_second", 32'(und5), 2);
      end
      enable5 = 1'b0;
      chk("pace_sb_empty", 32'(q5.size()), 0);

      // Backpressure: first sample held for 12 cycles across two ticks.
      do_reset();
      wr5(16'h1111);
      wr5(16'hFFFE);
      enable5 = 1'b1;
      t = 0;
      while (!tvalid5 && t < 20) begin step(); t++; end
      if (!tvalid5) fail_msg("bp_tvalid_timeout");
      for (int k = 0; k < 12; k++) begin
         chk("bp_hold_tvalid", 32'(tvalid5), 1);
         chk("bp_hold_tdata",  32'(tdata5),  32'h1111);
         step();
      end
      tready5 = 1'b1;
      t = 0;
      while ((q5.size() != 0 || tvalid5) && t < 30) begin step(); t++; end
      chk("bp_drained", 32'(q5.size()), 0);
      chk("bp_stall",   32'(stall5),    2);
      chk("bp_level",   32'(level5),    0);
      enable5 = 1'b0;

      // Overflow: table-driven writes, then drain; the dropped sample must not appear.
      do_reset();
      tready5 = 1'b1;
      foreach (vecs[i]) begin
         wr_en5   = vecs[i].wr_en;
         wr_data5 = vecs[i].data;
         if (vecs[i].push) q5.push_back(vecs[i].data);
         step();
         chk($sformatf("ovf_full_v%0d", i),  32'(full5),  32'(vecs[i].exp_full));
         chk($sformatf("ovf_level_v%0d", i), 32'(level5), 32'(vecs[i].exp_level));
         chk($sformatf("ovf_count_v%0d", i), 32'(ovf5),   32'(vecs[i].exp_ovf));
      end
      wr_en5  = 1'b0;
      enable5 = 1'b1;
      t = 0;
      while (q5.size() != 0 && t < 150) begin step(); t++; end
      repeat (12) step();
      chk("ovf_drained", 32'(q5.size()), 0);
      chk("ovf_tvalid",  32'(tvalid5),   0);
      chk("ovf_level",   32'(level5),    0);
      chk("ovf_final",   32'(ovf5),      1);
      enable5 = 1'b0;

      // Back-to-back at RATE_DIV=1: four consecutive valid cycles, then underrun.
      do_reset();
      tready1 = 1'b1;
      wr1(16'hA001);
      wr1(16'hA002);
      wr1(16'h5A5A);
      wr1(16'hFFFF);
      enable1 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk($sformatf("b2b_tvalid_c%0d", i), 32'(tvalid1), 32'(i <= 4));
         if (i == 4) chk("b2b_und_before", 32'(und1), 0);
         if (i == 5) chk("b2b_und_after",  32'(und1), 1);
         if (i == 5) chk("b2b_level",      32'(level1), 0);
      end
      enable1 = 1'b0;
      chk("b2b_sb_empty", 32'(q1.size()), 0);

      // Reset mid-operation with a held sample and five queued.
      do_reset();
      for (int i = 0; i < 6; i++) wr5(16'h0C00 + 16'(i));
      enable5 = 1'b1;
      t = 0;
      while (!tvalid5 && t < 20) begin step(); t++; end
      if (!tvalid5) fail_msg("mid_tvalid_timeout");
      repeat (6) step();
      chk("mid_pre_level",  32'(level5),  5);
      chk("mid_pre_tvalid", 32'(tvalid5), 1);
      chk("mid_pre_stall",  32'(stall5),  1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", 32'(tvalid5), 0);
      chk("mid_rst_level",  32'(level5),  0);
      chk("mid_rst_cnts",   32'(und5 | stall5 | ovf5), 0);
      q5.delete();
      enable5 = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      wr5(16'h1234);
      tready5 = 1'b1;
      enable5 = 1'b1;
      t = 0;
      while ((q5.size() != 0 || tvalid5) && t < 20) begin step(); t++; end
      chk("mid_post_drained", 32'(q5.size()), 0);
      enable5 = 1'b0;

      repeat (5) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
